// File: rtl/alu_bist.sv
// Built-in self-test sequencer for the 32-bit ALU: drives command/operand pairs,
// checks result/iszero/overflow against a golden model and captures the first failure.
module alu_bist #(
   parameter int unsigned NUM_VECTORS = 64,
   parameter int unsigned SETTLE      = 1,
   parameter logic [31:0] SEED        = 32'hACE12345
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic [2:0]  alu_command,
   output logic [31:0] alu_operand_a,
   output logic [31:0] alu_operand_b,
   input  logic [31:0] alu_result,
   input  logic        alu_iszero,
   input  logic        alu_overflow,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [15:0] err_count,
   output logic [2:0]  fail_command,
   output logic [31:0] fail_a,
   output logic [31:0] fail_b,
   output logic [31:0] fail_result
);

   typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_WAIT, S_CHECK, S_FINISH} state_e;
   typedef enum logic [2:0] {
      CMD_ADD  = 3'd0, CMD_SUB = 3'd1, CMD_XOR = 3'd2, CMD_SLT = 3'd3,
      CMD_AND  = 3'd4, CMD_NAND = 3'd5, CMD_NOR = 3'd6, CMD_OR = 3'd7
   } cmd_e;

   localparam int unsigned VW = $clog2(NUM_VECTORS);
   localparam int unsigned WW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [31:0]   SEED_EFF  = (SEED == 32'h0) ? 32'h00000001 : SEED;
   localparam logic [VW-1:0] LAST_VEC  = VW'(NUM_VECTORS - 1);
   localparam logic [WW-1:0] LAST_WAIT = WW'(SETTLE - 1);

   state_e        state;
   logic [2:0]    cmd;
   logic [VW-1:0] vidx;
   logic [WW-1:0] wcnt;
   logic [31:0]   lfsr;
   logic          captured;

   logic [31:0]   exp_r;
   logic          exp_ov;
   logic          chk_ov;
   logic          mismatch;
   logic [15:0]   err_inc;

   function automatic logic [31:0] lfsr_step(input logic [31:0] x);
      return {x[30:0], x[31] ^ x[21] ^ x[1] ^ x[0]};
   endfunction

   always_comb begin
      exp_r  = '0;
      exp_ov = 1'b0;
      chk_ov = 1'b0;
      case (cmd_e'(alu_command))
         CMD_ADD: begin
            exp_r  = alu_operand_a + alu_operand_b;
            chk_ov = 1'b1;
            exp_ov = (alu_operand_a[31] == alu_operand_b[31]) && (exp_r[31] != alu_operand_a[31]);
         end
         CMD_SUB: begin
            exp_r  = alu_operand_a - alu_operand_b;
            chk_ov = 1'b1;
            exp_ov = (alu_operand_a[31] != alu_operand_b[31]) && (exp_r[31] != alu_operand_a[31]);
         end
         CMD_XOR:  exp_r = alu_operand_a ^ alu_operand_b;
         CMD_SLT:  exp_r = {31'b0, $signed(alu_operand_a) < $signed(alu_operand_b)};
         CMD_AND:  exp_r = alu_operand_a & alu_operand_b;
         CMD_NAND: exp_r = ~(alu_operand_a & alu_operand_b);
         CMD_NOR:  exp_r = ~(alu_operand_a | alu_operand_b);
         CMD_OR:   exp_r = alu_operand_a | alu_operand_b;
         default:  exp_r = '0;
      endcase
      mismatch = (alu_result != exp_r) || (alu_iszero != (exp_r == '0)) ||
                 (chk_ov && (alu_overflow != exp_ov));
      err_inc  = (err_count == '1) ? err_count : err_count + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         cmd           <= '0;
         vidx          <= '0;
         wcnt          <= '0;
         lfsr          <= SEED_EFF;
         captured      <= 1'b0;
         alu_command   <= '0;
         alu_operand_a <= '0;
         alu_operand_b <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         pass          <= 1'b0;
         err_count     <= '0;
         fail_command  <= '0;
         fail_a        <= '0;
         fail_b        <= '0;
         fail_result   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  err_count    <= '0;
                  pass         <= 1'b0;
                  fail_command <= '0;
                  fail_a       <= '0;
                  fail_b       <= '0;
                  fail_result  <= '0;
                  captured     <= 1'b0;
                  busy         <= 1'b1;
                  lfsr         <= SEED_EFF;
                  cmd          <= '0;
                  vidx         <= '0;
                  state        <= S_DRIVE;
               end
            end
            S_DRIVE: begin
               alu_command <= cmd;
               wcnt        <= '0;
               state       <= S_WAIT;
               // operands change only on the first command of each vector
               if (cmd == 3'd0) begin
                  if (vidx == VW'(0)) begin
                     alu_operand_a <= 32'h7FFFFFFF;
                     alu_operand_b <= 32'h7FFFFFFF;
                  end else if (vidx == VW'(1)) begin
                     alu_operand_a <= 32'h80000000;
                     alu_operand_b <= 32'h00000001;
                  end else begin
                     alu_operand_a <= lfsr;
                     alu_operand_b <= lfsr_step(lfsr);
                     lfsr          <= lfsr_step(lfsr_step(lfsr));
                  end
               end
            end
            S_WAIT: begin
               if (wcnt == LAST_WAIT) state <= S_CHECK;
               else                   wcnt  <= wcnt + WW'(1);
            end
            S_CHECK: begin
               if (mismatch) begin
                  err_count <= err_inc;
                  if (!captured) begin
                     captured     <= 1'b1;
                     fail_command <= alu_command;
                     fail_a       <= alu_operand_a;
                     fail_b       <= alu_operand_b;
                     fail_result  <= alu_result;
                  end
               end
               cmd <= cmd + 3'd1;
               if (cmd == 3'd7 && vidx == LAST_VEC) begin
                  state <= S_FINISH;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (err_count == '0) && !mismatch;
               end else begin
                  if (cmd == 3'd7) vidx <= vidx + VW'(1);
                  state <= S_DRIVE;
               end
            end
            S_FINISH: begin
               done  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_bist.sv
// Scoreboard bench for alu_bist: a behavioural ALU with injectable faults, directed runs,
// expected run results and operand sequences queued at start and checked by monitors.
module tb_alu_bist;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start1 = 1'b0, start2 = 1'b0;
   logic [1:0] fault = 2'd0;

   logic [2:0]  cmd1, cmd2, fcmd1, fcmd2;
   logic [31:0] a1, b1, a2, b2, res1, res2, fa1, fb1, fr1, fa2, fb2, fr2;
   logic        z1, z2, ov1, ov2, busy1, busy2, done1, done2, pass1, pass2;
   logic [15:0] err1, err2;
   logic [33:0] f1, f2;

   always #5 clk = ~clk;

   alu_bist #(.NUM_VECTORS(2), .SETTLE(1), .SEED(32'hACE12345)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1),
      .alu_command(cmd1), .alu_operand_a(a1), .alu_operand_b(b1),
      .alu_result(res1), .alu_iszero(z1), .alu_overflow(ov1),
      .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
      .fail_command(fcmd1), .fail_a(fa1), .fail_b(fb1), .fail_result(fr1));

   alu_bist #(.NUM_VECTORS(64), .SETTLE(3), .SEED(32'hACE12345)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2),
      .alu_command(cmd2), .alu_operand_a(a2), .alu_operand_b(b2),
      .alu_result(res2), .alu_iszero(z2), .alu_overflow(ov2),
      .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
      .fail_command(fcmd2), .fail_a(fa2), .fail_b(fb2), .fail_result(fr2));

   // behavioural ALU: returns {overflow, iszero, result}
   function automatic logic [33:0] alu_f(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
      logic signed [32:0] w;
      logic [31:0] r;
      logic ov;
      w  = '0;
      ov = 1'b0;
      case (c)
         3'd0: begin w = $signed({a[31], a}) + $signed({b[31], b}); r = w[31:0]; ov = w[32] != w[31]; end
         3'd1: begin w = $signed({a[31], a}) - $signed({b[31], b}); r = w[31:0]; ov = w[32] != w[31]; end
         3'd2: r = a ^ b;
         3'd3: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         3'd4: r = a & b;
         3'd5: r = ~(a & b);
         3'd6: r = ~(a | b);
         default: r = a | b;
      endcase
      return {ov, r == 32'd0, r};
   endfunction

   always_comb begin
      f1   = alu_f(cmd1, a1, b1);
      res1 = f1[31:0];
      if (fault == 2'd1 && cmd1 == 3'd2) res1[0] = 1'b0;
      z1   = (res1 == 32'd0);
      ov1  = (fault == 2'd2) ? 1'b0 : f1[33];
      f2   = alu_f(cmd2, a2, b2);
      res2 = f2[31:0];
      z2   = f2[32];
      ov2  = f2[33];
   end

   int unsigned passed = 0, total = 0;

   task automatic chk(input string name, input logic [95:0] got, input logic [95:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s got=%0h exp=%0h", name, got, exp);
   endtask

   typedef struct {
      bit          pass;
      int unsigned errs;
      logic [2:0]  fcmd;
      logic [31:0] fa, fb, fr;
      int unsigned cycles;
   } exp_t;

   exp_t        q1[$], q2[$];
   exp_t        e1, e2;
   logic [66:0] opq1[$];
   logic [66:0] ops2[512];
   logic [66:0] prev2[512];
   bit          have_prev2 = 0;
   int unsigned bcnt1 = 0, bcnt2 = 0;

   // monitor for the 2-vector instance: op sequence at each CHECK cycle, run summary at done
   always @(negedge clk) begin
      if (!rst_n) begin
         bcnt1 = 0;
         opq1.delete();
      end else begin
         if (busy1) begin
            if (bcnt1 % 3 == 2) begin
               chk("op1_pending", 96'(opq1.size() != 0), 96'(1));
               if (opq1.size() != 0) chk("op1_seq", 96'({cmd1, a1, b1}), 96'(opq1.pop_front()));
            end
            bcnt1++;
         end
         if (done1) begin
            chk("done1_expected", 96'(q1.size() != 0), 96'(1));
            if (q1.size() != 0) begin
               e1 = q1.pop_front();
               chk("busy1_cycles", 96'(bcnt1), 96'(e1.cycles));
               chk("busy1_low",    96'(busy1), 96'(0));
               chk("pass1",        96'(pass1), 96'(e1.pass));
               chk("err_count1",   96'(err1),  96'(e1.errs));
               chk("fail_command1", 96'(fcmd1), 96'(e1.fcmd));
               chk("fail_a1",      96'(fa1),   96'(e1.fa));
               chk("fail_b1",      96'(fb1),   96'(e1.fb));
               chk("fail_result1", 96'(fr1),   96'(e1.fr));
            end
            bcnt1 = 0;
         end
      end
   end

   // monitor for the 64-vector instance: records the operand stream for directed and repeat checks
   always @(negedge clk) begin
      if (!rst_n) begin
         bcnt2 = 0;
      end else begin
         if (busy2) begin
            if (bcnt2 % 5 == 4 && bcnt2 / 5 < 512) ops2[bcnt2 / 5] = {cmd2, a2, b2};
            bcnt2++;
         end
         if (done2) begin
            chk("done2_expected", 96'(q2.size() != 0), 96'(1));
            if (q2.size() != 0) begin
               e2 = q2.pop_front();
               chk("busy2_cycles", 96'(bcnt2), 96'(e2.cycles));
               chk("pass2",        96'(pass2), 96'(e2.pass));
               chk("err_count2",   96'(err2),  96'(e2.errs));
            end
            chk("op2_vec0",  96'(ops2[0]),  96'({3'd0, 32'h7FFFFFFF, 32'h7FFFFFFF}));
            chk("op2_vec1",  96'(ops2[15]), 96'({3'd7, 32'h80000000, 32'h00000001}));
            chk("op2_vec2",  96'(ops2[16]), 96'({3'd0, 32'hACE12345, 32'h59C2468B}));
            chk("op2_vec2c", 96'(ops2[17]), 96'({3'd1, 32'hACE12345, 32'h59C2468B}));
            chk("op2_vec3a", 96'(ops2[24][63:32]), 96'(32'hB3848D16));
            if (have_prev2) begin
               int unsigned nd;
               nd = 0;
               for (int unsigned k = 0; k < 512; k++) if (ops2[k] !== prev2[k]) nd++;
               chk("op2_repeat_diffs", 96'(nd), 96'(0));
            end
            prev2 = ops2;
            have_prev2 = 1;
            bcnt2 = 0;
         end
      end
   end

   task automatic push_run1(input bit p, input int unsigned errs, input logic [2:0] fc,
                            input logic [31:0] fa, input logic [31:0] fb, input logic [31:0] fr);
      exp_t e;
      e.pass = p; e.errs = errs; e.fcmd = fc; e.fa = fa; e.fb = fb; e.fr = fr; e.cycles = 48;
      q1.push_back(e);
   endtask

   task automatic push_ops1();
      for (int unsigned c = 0; c < 8; c++) opq1.push_back({3'(c), 32'h7FFFFFFF, 32'h7FFFFFFF});
      for (int unsigned c = 0; c < 8; c++) opq1.push_back({3'(c), 32'h80000000, 32'h00000001});
   endtask

   task automatic pulse1();
      @(negedge clk) start1 = 1'b1;
      @(negedge clk) start1 = 1'b0;
   endtask

   task automatic wait_done(input int unsigned which, input int unsigned lim);
      bit got;
      got = 0;
      for (int unsigned i = 0; i < lim; i++) begin
         @(negedge clk);
         if ((which == 1) ? done1 : done2) begin
            got = 1;
            break;
         end
      end
      chk(which == 1 ? "done1_timeout" : "done2_timeout", 96'(got), 96'(1));
   endtask

   initial begin
      exp_t e;
      // reset state
      repeat (3) @(negedge clk);
      chk("rst_busy",  96'({busy1, busy2}), 96'(0));
      chk("rst_done",  96'({done1, done2}), 96'(0));
      chk("rst_pass",  96'({pass1, pass2}), 96'(0));
      chk("rst_err",   96'({err1, err2}),   96'(0));
      chk("rst_cmd",   96'({cmd1, cmd2}),   96'(0));
      chk("rst_fail",  96'({fcmd1, fa1, fb1, fr1}), 96'(0));
      chk("rst_ops",   96'({a1, b1}),       96'(0));
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // correct ALU
      push_run1(1, 0, 3'd0, 32'h0, 32'h0, 32'h0);
      push_ops1();
      pulse1();
      wait_done(1, 200);
      @(negedge clk);
      chk("done1_one_cycle", 96'(done1), 96'(0));
      chk("pass1_holds",     96'(pass1), 96'(1));

      // XOR result bit0 stuck low
      fault = 2'd1;
      push_run1(0, 1, 3'd2, 32'h80000000, 32'h00000001, 32'h80000000);
      push_ops1();
      pulse1();
      wait_done(1, 200);

      // overflow stuck low
      fault = 2'd2;
      push_run1(0, 2, 3'd0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFE);
      push_ops1();
      pulse1();
      wait_done(1, 200);
      fault = 2'd0;

      // start while busy is ignored
      push_run1(1, 0, 3'd0, 32'h0, 32'h0, 32'h0);
      push_ops1();
      pulse1();
      repeat (10) @(negedge clk);
      start1 = 1'b1;
      @(negedge clk) start1 = 1'b0;
      wait_done(1, 200);
      repeat (60) @(negedge clk);

      // reset mid-run aborts without done
      push_ops1();
      pulse1();
      repeat (20) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk("abort_busy_async", 96'(busy1), 96'(0));
      repeat (2) @(negedge clk);
      chk("abort_err_clear", 96'(err1), 96'(0));
      rst_n = 1'b1;
      repeat (60) @(negedge clk);
      chk("abort_no_done_idle", 96'(busy1), 96'(0));

      push_run1(1, 0, 3'd0, 32'h0, 32'h0, 32'h0);
      push_ops1();
      pulse1();
      wait_done(1, 200);

      // long runs, repeated twice
      for (int r = 0; r < 2; r++) begin
         e.pass = 1; e.errs = 0; e.fcmd = '0; e.fa = '0; e.fb = '0; e.fr = '0; e.cycles = 2560;
         q2.push_back(e);
         @(negedge clk) start2 = 1'b1;
         @(negedge clk) start2 = 1'b0;
         wait_done(2, 3000);
         repeat (3) @(negedge clk);
      end

      chk("q1_drained",   96'(q1.size()),   96'(0));
      chk("opq1_drained", 96'(opq1.size()), 96'(0));
      chk("q2_drained",   96'(q2.size()),   96'(0));
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/alu_bist.md
Name: alu_bist

Overview:
Built-in self-test sequencer for the 32-bit ALU. It is the stimulus-driving and result-checking end of the ALU's command/operand interface.
- Drives command and operands into an alu instance.
- Samples result, iszero and overflow.
- Compares them against an internal golden model and reports pass/fail with first-failure capture.
- Sits beside the ALU in the datapath test harness and is started by a single pulse.

Parameters:
NUM_VECTORS, 64, operand pairs per run (>=2); each pair is exercised with all 8 commands
SETTLE, 1, cycles the ALU inputs are held before results are sampled (>=1)
SEED, 32'hACE12345, LFSR seed; 0 is replaced by 32'h00000001

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a run; sampled only in IDLE
alu_command  out  3  ALU command: ADD=0 SUB=1 XOR=2 SLT=3 AND=4 NAND=5 NOR=6 OR=7
alu_operand_a  out  32  ALU operandA
alu_operand_b  out  32  ALU operandB
alu_result  in  32  ALU result
alu_iszero  in  1  ALU zero flag
alu_overflow  in  1  ALU overflow flag
busy  out  1  run in progress
done  out  1  one-cycle pulse at end of run
pass  out  1  run finished with err_count==0; valid from done until next start
err_count  out  16  mismatching checks, saturates at 16'hFFFF
fail_command  out  3  command of first mismatch
fail_a  out  32  operandA of first mismatch
fail_b  out  32  operandB of first mismatch
fail_result  out  32  alu_result observed at first mismatch

Behaviour:
- Reset (async, rst_n=0): all outputs 0, FSM in IDLE, LFSR loaded with SEED, first-fail-captured flag cleared. Reset mid-run aborts immediately; no done pulse is issued.
- FSM states: IDLE -> DRIVE -> WAIT (SETTLE cycles) -> CHECK -> DRIVE or FINISH -> IDLE.
- IDLE:
  - start=1 at a clock edge clears err_count, pass, fail_* and the captured flag, sets busy=1 and reloads the LFSR.
  - Next state DRIVE with vector index 0 and command 0.
- DRIVE (1 cycle): register alu_command, alu_operand_a and alu_operand_b.
- WAIT: hold the ALU inputs for SETTLE cycles.
- CHECK (1 cycle): compare the ALU outputs against the golden model.
  - On mismatch: err_count+1 (saturating). If not yet captured, load fail_* and set the captured flag.
  - Advance to the next command. After command 7, advance to the next vector and reset command to 0.
  - After the last check of vector NUM_VECTORS-1, go to FINISH.
- FINISH (1 cycle): busy=0, done=1, pass=(err_count==0). Next state IDLE; pass and fail_* hold.
- Cycle count: busy is high for exactly NUM_VECTORS*8*(SETTLE+2) cycles; done follows in the next cycle.
- start while busy or in FINISH is ignored.
- ALU outputs keep their last values in IDLE.
- Operand vectors:
  - Vector 0: A=B=32'h7FFFFFFF.
  - Vector 1: A=32'h80000000, B=32'h00000001.
  - Vector k>=2: A=LFSR, then the LFSR steps once, B=LFSR, then it steps once more.
  - LFSR: Fibonacci, shift left, new bit0 = bit31^bit21^bit1^bit0.
- Golden model, all arithmetic modulo 2^32:
  - ADD: A+B. SUB: A-B.
  - XOR, AND, OR: bitwise. NAND: ~(A&B). NOR: ~(A|B).
  - SLT: 32'd1 if $signed(A)<$signed(B), else 0.
- Checks:
  - result and iszero (expected = result==0) are checked for every command.
  - overflow is checked only for ADD and SUB; it is ignored for other commands.
  - ADD overflow = A[31]==B[31] && R[31]!=A[31].
  - SUB overflow = A[31]!=B[31] && R[31]!=A[31].
- Each CHECK is one error event, regardless of how many fields mismatch.

Test Plan:
1. Reset: rst_n=0 with clk running -> busy=done=pass=0, err_count=0, alu_command=0, fail_*=0.
2. Correct ALU, NUM_VECTORS=2, SETTLE=1: pulse start.
   - busy high for 48 cycles, then done=1 for one cycle, pass=1, err_count=0.
   - Commands observed in order 0..7 twice, first with A=B=7FFFFFFF.
   - Vector-1 SLT expects result 1.
3. ALU wrapper forcing result[0]=0 on XOR, NUM_VECTORS=2:
   - pass=0, err_count=1.
   - fail_command=2, fail_a=80000000, fail_b=00000001, fail_result=80000000.
4. ALU wrapper forcing overflow=0, NUM_VECTORS=2:
   - First fail fail_command=0, fail_a=fail_b=7FFFFFFF, fail_result=FFFFFFFE.
   - err_count=2 (vector-0 ADD, vector-1 SUB).
5. start pulsed again while busy -> run length unchanged, single done.
   - rst_n low mid-run -> busy=0 asynchronously, no done.
   - A new start then produces the full 48-cycle run with identical operand sequence.
6. NUM_VECTORS=64, SETTLE=3, correct ALU -> busy exactly 2560 cycles, pass=1.
   - LFSR operands repeat bit-identically across two consecutive runs.
